mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the data port of the in-order core.
- Sits between the control path / datapath memory bundles and the memory model or bus bridge.
- Allows one outstanding transaction. Data has priority, with a starvation guard for fetch.
- Responses are steered back to the port that owns the in-flight transaction.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits; the next grant then goes to fetch

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
imem_req_valid  in  1  fetch request valid (read-only, word)
imem_req_ready  out  1  fetch request accepted this cycle
imem_req_addr  in  ADDR_W  fetch address
imem_res_valid  out  1  fetch response valid
imem_res_data  out  DATA_W  fetch response data
dmem_req_valid  in  1  data request valid
dmem_req_ready  out  1  data request accepted this cycle
dmem_req_addr  in  ADDR_W  data address
dmem_req_data  in  DATA_W  store data
dmem_req_fcn  in  1  M_XRD=0 / M_XWR=1
dmem_req_typ  in  3  MT_B/H/W/BU/HU/WU mask type
dmem_res_valid  out  1  data response valid; also acks writes
dmem_res_data  out  DATA_W  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  memory address
mem_req_data  out  DATA_W  memory write data
mem_req_fcn  out  1  memory read/write
mem_req_typ  out  3  memory mask type
mem_res_valid  in  1  memory response (reads and writes)
mem_res_data  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- All outputs are 0 during and after reset. The streak counter resets to 0.
- In IDLE, grant is computed combinationally:
  - dmem_req_valid && !(imem_req_valid && streak==MAX_D_STREAK) -> D.
  - else imem_req_valid -> I.
  - else none.
- mem_req_* is driven from the granted port in the same cycle (0 added request latency).
- For an imem grant: fcn=M_XRD, typ=MT_WU, data=0.
- {imem,dmem}_req_ready = granted && mem_req_ready. It is never asserted outside IDLE.
- A handshake (mem_req_valid && mem_req_ready) moves IDLE -> BUSY_I or BUSY_D. No handshake: stay in IDLE and re-arbitrate next cycle. Grant may change while memory stalls.
- In BUSY_x, mem_req_valid=0. mem_res_valid is passed combinationally to x_res_valid, with mem_res_data as data, and the FSM returns to IDLE in the same cycle.
- A new grant is possible the cycle after the response. Minimum turnaround is 2 cycles per transaction.
- Non-owner res_valid stays 0. Non-owner res_data is 0.
- Streak counter:
  - D granted while imem_req_valid -> increment, saturating at MAX_D_STREAK.
  - I granted, or imem_req_valid low -> clear to 0.
- mem_res_valid in IDLE (stale response after reset, or memory error) is dropped. State is unchanged.
- Reset mid-transaction: immediate return to IDLE; the in-flight response is discarded.
- Both requests valid with streak<MAX_D_STREAK: D wins. Only the winner sees ready.

Optional Feature:
MEM_ARBITER_PERF_EN:
- Defined: adds outputs perf_i_grants (32), perf_d_grants (32) and perf_conflict_cycles (32).
- perf_conflict_cycles counts IDLE cycles with both requests valid.
- perf_i_grants / perf_d_grants count handshakes per port.
- All counters wrap at 2^32 and clear on reset.
- Undefined: no counters, no extra ports, behaviour otherwise identical.

Decomposition:
- Bundle package: add ArbState enum (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D) and ArbGrant enum (GNT_NONE, GNT_I, GNT_D).
- Reuse existing M_XRD/M_XWR and MT_* constants.
- One sub-module, mem_arbiter_grant, holds the streak counter and the combinational priority pick (inputs: both valids, handshake, grant_en; output: ArbGrant). The top level holds the FSM, muxing and optional counters.

Test Plan:
- Fetch only, addr 0x100, memory responds 0xDEADBEEF after 3 cycles -> imem_res_valid 1 cycle with 0xDEADBEEF; dmem_res_valid stays 0; mem_req_typ=MT_WU.
- Both valid every cycle, MAX_D_STREAK=4, single-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I.
- dmem SW addr 0x200 data 0x12345678, mem_req_ready low 2 cycles -> mem_req_* held stable; dmem_req_ready only in the acceptance cycle; write ack appears on dmem_res_valid.
- Reset asserted in BUSY_D, memory returns response 1 cycle after release -> response dropped; no res_valid on either port; next request proceeds normally.
- mem_res_valid pulsed in IDLE with no requests -> no output activity; state remains IDLE.
- With MEM_ARBITER_PERF_EN: 10 conflict cycles, 6 D / 4 I grants -> perf counters read 10/6/4; after reset all read 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared bundle types for the fetch/data memory arbiter.
// Memory command and mask constants plus arbiter state and grant enums.
package mem_arbiter_pkg;

  localparam logic M_XRD = 1'b0;
  localparam logic M_XWR = 1'b1;

  localparam logic [2:0] MT_X  = 3'd0;
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_D  = 3'd4;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;
  localparam logic [2:0] MT_WU = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D
  } ArbState;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } ArbGrant;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between core ports, arbiter and memory.
// slave = arbiter view, master = core/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_res_valid;
  logic [DATA_W-1:0] imem_res_data;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_data;
  logic              dmem_req_fcn;
  logic [2:0]        dmem_req_typ;
  logic              dmem_res_valid;
  logic [DATA_W-1:0] dmem_res_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_fcn;
  logic [2:0]        mem_req_typ;
  logic              mem_res_valid;
  logic [DATA_W-1:0] mem_res_data;

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_res_valid, imem_res_data,
    input  dmem_req_valid, dmem_req_addr, dmem_req_data,
    input  dmem_req_fcn, dmem_req_typ,
    output dmem_req_ready, dmem_res_valid, dmem_res_data,
    output mem_req_valid, mem_req_addr, mem_req_data,
    output mem_req_fcn, mem_req_typ,
    input  mem_req_ready, mem_res_valid, mem_res_data
  );

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_res_valid, imem_res_data,
    output dmem_req_valid, dmem_req_addr, dmem_req_data,
    output dmem_req_fcn, dmem_req_typ,
    input  dmem_req_ready, dmem_res_valid, dmem_res_data,
    input  mem_req_valid, mem_req_addr, mem_req_data,
    input  mem_req_fcn, mem_req_typ,
    output mem_req_ready, mem_res_valid, mem_res_data
  );

endinterface

// File: rtl/mem_arbiter_grant.sv
// Data-first priority pick with a saturating streak counter
// that hands the next grant to a waiting fetch.
module mem_arbiter_grant
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_valid,
  input  logic    d_valid,
  input  logic    hs,
  input  logic    grant_en,
  output ArbGrant gnt
);

  localparam int SW =
    (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          fetch_due;

  always_comb begin
    fetch_due = i_valid && (streak_q == MAX_S);
    gnt       = GNT_NONE;
    if (grant_en) begin
      if (d_valid && !fetch_due) gnt = GNT_D;
      else if (i_valid)          gnt = GNT_I;
    end
  end

  // Streak only measures data grants made while fetch is waiting.
  always_comb begin
    streak_d = streak_q;
    if (!i_valid)
      streak_d = '0;
    else if (hs && gnt == GNT_I)
      streak_d = '0;
    else if (hs && gnt == GNT_D && streak_q != MAX_S)
      streak_d = streak_q + SW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Define MEM_ARBITER_PERF_EN to add grant/conflict performance counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_conflict_cycles
`endif
);

  ArbState state_q, state_d;
  ArbGrant gnt;
  logic    grant_en;
  logic    hs;

  assign grant_en = (state_q == ARB_IDLE) && !reset;
  assign hs       = bus.mem_req_valid && bus.mem_req_ready;

  mem_arbiter_grant #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.imem_req_valid),
    .d_valid (bus.dmem_req_valid),
    .hs      (hs),
    .grant_en(grant_en),
    .gnt     (gnt)
  );

  always_comb begin
    state_d            = state_q;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_addr   = {ADDR_W{1'b0}};
    bus.mem_req_data   = {DATA_W{1'b0}};
    bus.mem_req_fcn    = M_XRD;
    bus.mem_req_typ    = MT_X;
    bus.imem_req_ready = 1'b0;
    bus.dmem_req_ready = 1'b0;
    bus.imem_res_valid = 1'b0;
    bus.imem_res_data  = {DATA_W{1'b0}};
    bus.dmem_res_valid = 1'b0;
    bus.dmem_res_data  = {DATA_W{1'b0}};
    unique case (state_q)
      ARB_IDLE: begin
        unique case (gnt)
          GNT_D: begin
            bus.mem_req_valid  = 1'b1;
            bus.mem_req_addr   = bus.dmem_req_addr;
            bus.mem_req_data   = bus.dmem_req_data;
            bus.mem_req_fcn    = bus.dmem_req_fcn;
            bus.mem_req_typ    = bus.dmem_req_typ;
            bus.dmem_req_ready = bus.mem_req_ready;
          end
          GNT_I: begin
            bus.mem_req_valid  = 1'b1;
            bus.mem_req_addr   = bus.imem_req_addr;
            bus.mem_req_fcn    = M_XRD;
            bus.mem_req_typ    = MT_WU;
            bus.imem_req_ready = bus.mem_req_ready;
          end
          default: ;
        endcase
        if (hs)
          state_d = (gnt == GNT_D) ? ARB_BUSY_D : ARB_BUSY_I;
      end
      ARB_BUSY_I: begin
        if (bus.mem_res_valid) begin
          bus.imem_res_valid = 1'b1;
          bus.imem_res_data  = bus.mem_res_data;
          state_d            = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        if (bus.mem_res_valid) begin
          bus.dmem_res_valid = 1'b1;
          bus.dmem_res_data  = bus.mem_res_data;
          state_d            = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] pi_q, pi_d, pd_q, pd_d, pc_q, pc_d;

  always_comb begin
    pi_d = pi_q + 32'(hs && gnt == GNT_I);
    pd_d = pd_q + 32'(hs && gnt == GNT_D);
    pc_d = pc_q + 32'(grant_en && bus.imem_req_valid
                      && bus.dmem_req_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pi_q <= '0;
      pd_q <= '0;
      pc_q <= '0;
    end else begin
      pi_q <= pi_d;
      pd_q <= pd_d;
      pc_q <= pc_d;
    end
  end

  assign perf_i_grants        = pi_q;
  assign perf_d_grants        = pd_q;
  assign perf_conflict_cycles = pc_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + random bench for mem_arbiter against a transaction-level model.
// Honours MEM_ARBITER_PERF_EN for the optional counters.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] p_i, p_d, p_c;
`endif

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .perf_i_grants       (p_i),
    .perf_d_grants       (p_d),
    .perf_conflict_cycles(p_c)
`endif
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic        iv, dv, df, mrdy, mresv;
  logic [31:0] ia, da, dd, mresd;
  logic [2:0]  dt;

  // model: owner of in-flight transaction (0 none, 1 fetch, 2 data)
  int owner  = 0;
  int streak = 0;
  logic [31:0] m_i = 0, m_d = 0, m_c = 0;

  int   seen;
  logic o_irv, o_drv;
  logic [31:0] o_ird;

  int exp_ord [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iv = 0; dv = 0; df = 0; mrdy = 0; mresv = 0;
    ia = 0; da = 0; dd = 0; mresd = 0; dt = 0;
  endtask

  task automatic cyc(string tag);
    int g;
    logic e_mv, e_mf, e_ir, e_dr, e_irv, e_drv;
    logic [31:0] e_ma, e_md, e_ird, e_drd;
    logic [2:0] e_mt;
    bus.imem_req_valid = iv;
    bus.imem_req_addr  = ia;
    bus.dmem_req_valid = dv;
    bus.dmem_req_addr  = da;
    bus.dmem_req_data  = dd;
    bus.dmem_req_fcn   = df;
    bus.dmem_req_typ   = dt;
    bus.mem_req_ready  = mrdy;
    bus.mem_res_valid  = mresv;
    bus.mem_res_data   = mresd;
    @(negedge clk);
    g = 0;
    e_mv = 0; e_mf = 0; e_ir = 0; e_dr = 0; e_irv = 0; e_drv = 0;
    e_ma = 0; e_md = 0; e_ird = 0; e_drd = 0; e_mt = 0;
    if (!rst) begin
      if (owner == 0) begin
        if (dv && !(iv && streak == MAXS)) g = 2;
        else if (iv) g = 1;
        if (g == 2) begin
          e_mv = 1; e_ma = da; e_md = dd;
          e_mf = df; e_mt = dt; e_dr = mrdy;
        end else if (g == 1) begin
          e_mv = 1; e_ma = ia; e_mt = MT_WU; e_ir = mrdy;
        end
      end else if (mresv) begin
        if (owner == 1) begin e_irv = 1; e_ird = mresd; end
        else begin e_drv = 1; e_drd = mresd; end
      end
    end
    chk({tag, ".mem_valid"}, bus.mem_req_valid, e_mv);
    chk({tag, ".mem_addr"},  bus.mem_req_addr,  e_ma);
    chk({tag, ".mem_data"},  bus.mem_req_data,  e_md);
    chk({tag, ".mem_fcn"},   bus.mem_req_fcn,   e_mf);
    chk({tag, ".mem_typ"},   bus.mem_req_typ,   e_mt);
    chk({tag, ".i_ready"},   bus.imem_req_ready, e_ir);
    chk({tag, ".d_ready"},   bus.dmem_req_ready, e_dr);
    chk({tag, ".i_rvalid"},  bus.imem_res_valid, e_irv);
    chk({tag, ".i_rdata"},   bus.imem_res_data,  e_ird);
    chk({tag, ".d_rvalid"},  bus.dmem_res_valid, e_drv);
    chk({tag, ".d_rdata"},   bus.dmem_res_data,  e_drd);
`ifdef MEM_ARBITER_PERF_EN
    chk({tag, ".perf_i"}, p_i, m_i);
    chk({tag, ".perf_d"}, p_d, m_d);
    chk({tag, ".perf_c"}, p_c, m_c);
`endif
    seen  = bus.dmem_req_ready ? 2 : (bus.imem_req_ready ? 1 : 0);
    o_irv = bus.imem_res_valid;
    o_drv = bus.dmem_res_valid;
    o_ird = bus.imem_res_data;
    @(posedge clk);
    if (rst) begin
      owner = 0; streak = 0;
      m_i = 0; m_d = 0; m_c = 0;
    end else begin
      if (owner == 0) begin
        if (iv && dv) m_c++;
        if (g != 0 && mrdy) begin
          if (g == 1) begin m_i++; streak = 0; end
          else begin
            m_d++;
            if (iv) streak = (streak < MAXS) ? streak + 1 : MAXS;
          end
          owner = g;
        end
      end else if (mresv) begin
        owner = 0;
      end
      if (!iv) streak = 0;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;

    iv = 1; dv = 1; ia = 32'h44; da = 32'h88;
    mrdy = 1; mresv = 1; mresd = 32'h5;
    cyc("reset");
    rst = 0; idle();
    cyc("idle0");

    iv = 1; ia = 32'h100; mrdy = 1;
    cyc("fetch.req");
    chk("fetch.accept", seen, 1);
    iv = 0; mrdy = 0;
    cyc("fetch.w1");
    cyc("fetch.w2");
    mresv = 1; mresd = 32'hDEADBEEF;
    cyc("fetch.res");
    chk("fetch.rvalid", o_irv, 1);
    chk("fetch.rdata", o_ird, 32'hDEADBEEF);
    chk("fetch.d_quiet", o_drv, 0);
    idle();

    iv = 1; dv = 1; ia = 32'h500; da = 32'h600; mrdy = 1;
    for (int k = 0; k < 10; k++) begin
      mresv = 0;
      cyc("order.req");
      chk("order.grant", seen, exp_ord[k]);
      mresv = 1; mresd = 32'(k);
      cyc("order.res");
    end
    idle();

    dv = 1; df = M_XWR; dt = MT_W;
    da = 32'h200; dd = 32'h12345678; mrdy = 0;
    cyc("sw.stall1");
    chk("sw.noready1", seen, 0);
    cyc("sw.stall2");
    chk("sw.noready2", seen, 0);
    mrdy = 1;
    cyc("sw.accept");
    chk("sw.ready", seen, 2);
    idle(); mresv = 1;
    cyc("sw.ack");
    chk("sw.ackvalid", o_drv, 1);
    idle();

    dv = 1; df = M_XRD; dt = MT_W; da = 32'h300; mrdy = 1;
    cyc("rd.req");
    idle(); rst = 1;
    cyc("rd.reset");
    rst = 0; mresv = 1; mresd = 32'hAAAA5555;
    cyc("rd.stale");
    chk("rd.stale_d", o_drv, 0);
    chk("rd.stale_i", o_irv, 0);
    idle(); iv = 1; ia = 32'h400; mrdy = 1;
    cyc("rd.next");
    chk("rd.next_grant", seen, 1);
    idle(); mresv = 1; mresd = 32'h0BAD_F00D;
    cyc("rd.next_res");
    chk("rd.next_rvalid", o_irv, 1);

    idle(); mresv = 1; mresd = 32'h1234;
    cyc("stray1");
    cyc("stray2");

    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      iv    = ($urandom_range(0, 3) != 0);
      dv    = ($urandom_range(0, 3) != 0);
      ia    = $urandom;
      da    = $urandom;
      dd    = $urandom;
      df    = 1'($urandom_range(0, 1));
      dt    = 3'($urandom_range(0, 7));
      mrdy  = ($urandom_range(0, 3) != 0);
      mresv = ($urandom_range(0, 2) == 0);
      mresd = $urandom;
      cyc("rand");
    end
    rst = 0; idle();
    cyc("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
